// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Evaluates a branch condition on two forwarded operands and returns the
//   outcome one cycle later. A table of 2-bit saturating counters predicts
//   the branch direction. Fetch reads that prediction combinationally, and
//   each accepted conditional branch trains the table.
//
// Optional feature:
//   BRANCH_STATS_EN - when defined, two saturating statistics counters are
//                     built: resolved conditional branches and mispredicted
//                     conditional branches. When undefined, no counter flops
//                     exist and both statistics outputs read as zero.
//
// Ports:
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high, dominant over requests
//   lk_pc         in   32     fetch PC used for the prediction lookup
//   lk_taken      out  1      predicted direction (counter MSB), combinational
//   req_valid     in   1      decode presents a branch this cycle
//   req_cond      in   3      0 none,1 beq,2 bne,3 bgez,4 bgtz,5 blez,6 bltz,7 always
//   req_pc        in   32     PC of the branch in decode
//   req_pred      in   1      prediction carried down from fetch
//   cmp0          in   WIDTH  rs operand
//   cmp1          in   WIDTH  rt operand
//   flush         in   1      kills the request presented this cycle
//   res_valid     out  1      registered outcome valid
//   res_taken     out  1      registered actual direction
//   res_mispred   out  1      registered (actual != predicted)
//   stat_branches out  CNT_W  resolved conditional branch count
//   stat_mispred  out  CNT_W  mispredicted conditional branch count
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 16,
    parameter int IDX_LSB   = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lk_pc,
    output logic             lk_taken,
    input  logic             req_valid,
    input  logic [2:0]       req_cond,
    input  logic [31:0]      req_pc,
    input  logic             req_pred,
    input  logic [WIDTH-1:0] cmp0,
    input  logic [WIDTH-1:0] cmp1,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispred,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [2:0] COND_NONE   = 3'd0;
    localparam logic [2:0] COND_BEQ    = 3'd1;
    localparam logic [2:0] COND_BNE    = 3'd2;
    localparam logic [2:0] COND_BGEZ   = 3'd3;
    localparam logic [2:0] COND_BGTZ   = 3'd4;
    localparam logic [2:0] COND_BLEZ   = 3'd5;
    localparam logic [2:0] COND_BLTZ   = 3'd6;
    localparam logic [2:0] COND_ALWAYS = 3'd7;

    localparam logic [1:0] PHT_WEAK_NT = 2'b01;

    // Saturating 2-bit counter step: taken moves toward 11, not-taken toward 00.
    function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : (cnt + 2'b01);
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : (cnt - 2'b01);
        end
        return nxt;
    endfunction

    logic [1:0]       r_pht [PHT_DEPTH];
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_acc;
    logic             w_cond_br;
    logic             w_taken;
    logic             w_mispred;
    logic             w_neg;
    logic             w_zero;
    logic             w_eq;
    logic             r_res_valid;
    logic             r_res_taken;
    logic             r_res_mispred;

    // PC bits outside the index field are intentionally ignored.
    logic             w_unused_pc;
    assign w_unused_pc = &{1'b0, lk_pc, req_pc};

    assign w_lk_idx  = lk_pc[IDX_LSB +: IDX_W];
    assign w_req_idx = req_pc[IDX_LSB +: IDX_W];
    assign lk_taken  = r_pht[w_lk_idx][1];

    assign w_acc     = req_valid & ~flush;
    // Only real compare conditions train the table and count in stats.
    assign w_cond_br = (req_cond != COND_NONE) && (req_cond != COND_ALWAYS);

    assign w_neg  = cmp0[WIDTH-1];
    assign w_zero = ~|cmp0;
    assign w_eq   = (cmp0 == cmp1);

    // Signed condition evaluation of the decode-stage branch.
    always_comb begin
        w_taken = 1'b0;
        case (req_cond)
            COND_NONE:   w_taken = 1'b0;
            COND_BEQ:    w_taken = w_eq;
            COND_BNE:    w_taken = ~w_eq;
            COND_BGEZ:   w_taken = ~w_neg;
            COND_BGTZ:   w_taken = ~w_neg & ~w_zero;
            COND_BLEZ:   w_taken = w_neg | w_zero;
            COND_BLTZ:   w_taken = w_neg;
            COND_ALWAYS: w_taken = 1'b1;
            default:     w_taken = 1'b0;
        endcase
    end

    assign w_mispred = w_taken ^ req_pred;

    // Pattern history table: reset to weak-NT, trained by accepted conditional branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= PHT_WEAK_NT;
            end
        end else if (w_acc && w_cond_br) begin
            r_pht[w_req_idx] <= pht_next(r_pht[w_req_idx], w_taken);
        end
    end

    // Registered outcome; direction and mispredict hold while no result is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid   <= 1'b0;
            r_res_taken   <= 1'b0;
            r_res_mispred <= 1'b0;
        end else begin
            r_res_valid <= w_acc;
            if (w_acc) begin
                r_res_taken   <= w_taken;
                r_res_mispred <= w_mispred;
            end
        end
    end

    assign res_valid   = r_res_valid;
    assign res_taken   = r_res_taken;
    assign res_mispred = r_res_mispred;

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] nxt;
        if (&v) begin
            nxt = v;
        end else begin
            nxt = v + CNT_ONE;
        end
        return nxt;
    endfunction

    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_mp;

    // Statistics for accepted conditional branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_br <= {CNT_W{1'b0}};
            r_stat_mp <= {CNT_W{1'b0}};
        end else if (w_acc && w_cond_br) begin
            r_stat_br <= sat_inc(r_stat_br);
            if (w_mispred) begin
                r_stat_mp <= sat_inc(r_stat_mp);
            end
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mp;
`else
    assign stat_branches = {CNT_W{1'b0}};
    assign stat_mispred  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit
// ----------------------------------------------------------------------------
// Directed bench for branch_resolve_unit. Uses PHT_DEPTH=32 so that PCs 0x40
// and 0x80 map to different predictor entries (16 and 0), and CNT_W=4 so that
// statistics saturation is reachable when BRANCH_STATS_EN is defined.
// ============================================================================
module tb_branch_resolve_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [31:0]      lk_pc;
    logic             lk_taken;
    logic             req_valid;
    logic [2:0]       req_cond;
    logic [31:0]      req_pc;
    logic             req_pred;
    logic [WIDTH-1:0] cmp0;
    logic [WIDTH-1:0] cmp1;
    logic             flush;
    logic             res_valid;
    logic             res_taken;
    logic             res_mispred;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    int n_vec = 0;
    int n_err = 0;

    logic [CNT_W-1:0] m_br;
    logic [CNT_W-1:0] m_mp;

    branch_resolve_unit #(
        .WIDTH    (WIDTH),
        .PHT_DEPTH(32),
        .IDX_LSB  (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lk_pc        (lk_pc),
        .lk_taken     (lk_taken),
        .req_valid    (req_valid),
        .req_cond     (req_cond),
        .req_pc       (req_pc),
        .req_pred     (req_pred),
        .cmp0         (cmp0),
        .cmp1         (cmp1),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_mispred  (res_mispred),
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic p, input logic f);
        req_valid = 1'b1;
        req_cond  = c;
        req_pc    = pc;
        cmp0      = a;
        cmp1      = b;
        req_pred  = p;
        flush     = f;
    endtask

    task automatic model_count(input logic mp);
        if (m_br != 4'hF) m_br = m_br + 4'h1;
        if (mp && (m_mp != 4'hF)) m_mp = m_mp + 4'h1;
    endtask

    task automatic check_stats(input string tag);
        n_vec++;
        if (stat_branches !== (STATS ? m_br : 4'h0)) begin
            n_err++;
            $error("FAIL %s_stat_br observed=%0h expected=%0h", tag, stat_branches, (STATS ? m_br : 4'h0));
        end
        n_vec++;
        if (stat_mispred !== (STATS ? m_mp : 4'h0)) begin
            n_err++;
            $error("FAIL %s_stat_mp observed=%0h expected=%0h", tag, stat_mispred, (STATS ? m_mp : 4'h0));
        end
    endtask

    logic [31:0] t3_a [3];
    logic        t3_exp [12];

    initial begin
        t3_a[0] = 32'h8000_0000; t3_a[1] = 32'h0; t3_a[2] = 32'h1;
        t3_exp[0] = 1'b0; t3_exp[1]  = 1'b0; t3_exp[2]  = 1'b1; t3_exp[3]  = 1'b1;
        t3_exp[4] = 1'b1; t3_exp[5]  = 1'b0; t3_exp[6]  = 1'b1; t3_exp[7]  = 1'b0;
        t3_exp[8] = 1'b1; t3_exp[9]  = 1'b1; t3_exp[10] = 1'b0; t3_exp[11] = 1'b0;

        m_br = 4'h0; m_mp = 4'h0;
        reset = 1'b1; req_valid = 1'b0; req_cond = 3'd0; req_pc = 32'h0;
        req_pred = 1'b0; cmp0 = 32'h0; cmp1 = 32'h0; flush = 1'b0; lk_pc = 32'h40;
        tick();
        tick();
        reset = 1'b0;

        #1;
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL t1_lk_taken observed=%0h", lk_taken); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $error("FAIL t1_res_valid observed=%0h", res_valid); end
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $error("FAIL t1_res_taken observed=%0h", res_taken); end
        n_vec++; if (res_mispred !== 1'b0) begin n_err++; $error("FAIL t1_res_mispred observed=%0h", res_mispred); end
        check_stats("t1");

        drive(3'd1, 32'h40, 32'h5, 32'h5, 1'b0, 1'b0);
        #1;
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL t2_lk_pre observed=%0h", lk_taken); end
        tick(); model_count(1'b1);
        req_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $error("FAIL t2_valid observed=%0h", res_valid); end
        n_vec++; if (res_taken !== 1'b1) begin n_err++; $error("FAIL t2_taken observed=%0h", res_taken); end
        n_vec++; if (res_mispred !== 1'b1) begin n_err++; $error("FAIL t2_mispred observed=%0h", res_mispred); end
        n_vec++; if (lk_taken !== 1'b1) begin n_err++; $error("FAIL t2_lk_10 observed=%0h", lk_taken); end
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $error("FAIL t2_idle_valid observed=%0h", res_valid); end
        n_vec++; if (res_taken !== 1'b1) begin n_err++; $error("FAIL t2_idle_hold_taken observed=%0h", res_taken); end
        drive(3'd1, 32'h40, 32'h5, 32'h5, 1'b1, 1'b0);
        tick(); model_count(1'b0);
        n_vec++; if (res_mispred !== 1'b0) begin n_err++; $error("FAIL t2_beq2_mispred observed=%0h", res_mispred); end
        tick(); model_count(1'b0);
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $error("FAIL t2_beq3_valid observed=%0h", res_valid); end
        n_vec++; if (lk_taken !== 1'b1) begin n_err++; $error("FAIL t2_lk_11 observed=%0h", lk_taken); end
        drive(3'd2, 32'h40, 32'h5, 32'h5, 1'b1, 1'b0);
        tick(); model_count(1'b1);
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $error("FAIL t2_bne_taken observed=%0h", res_taken); end
        n_vec++; if (res_mispred !== 1'b1) begin n_err++; $error("FAIL t2_bne_mispred observed=%0h", res_mispred); end
        n_vec++; if (lk_taken !== 1'b1) begin n_err++; $error("FAIL t2_lk_after_dec1 observed=%0h", lk_taken); end
        tick(); model_count(1'b1);
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL t2_lk_after_dec2 observed=%0h", lk_taken); end
        check_stats("t2");

        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 4; c++) begin
                drive(3'(c + 3), 32'h08, t3_a[i], 32'h0, 1'b0, 1'b0);
                tick(); model_count(t3_exp[i*4 + c]);
                n_vec++;
                if (res_taken !== t3_exp[i*4 + c]) begin
                    n_err++;
                    $error("FAIL t3_taken i=%0d c=%0d observed=%0h expected=%0h", i, c, res_taken, t3_exp[i*4 + c]);
                end
                n_vec++;
                if (res_mispred !== t3_exp[i*4 + c]) begin
                    n_err++;
                    $error("FAIL t3_mispred i=%0d c=%0d observed=%0h expected=%0h", i, c, res_mispred, t3_exp[i*4 + c]);
                end
            end
        end
        check_stats("t3");

        drive(3'd2, 32'h44, 32'h1, 32'h2, 1'b0, 1'b1);
        lk_pc = 32'h44;
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $error("FAIL t4_flush_valid observed=%0h", res_valid); end
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $error("FAIL t4_flush_hold_taken observed=%0h", res_taken); end
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL t4_flush_lk observed=%0h", lk_taken); end
        check_stats("t4a");
        drive(3'd2, 32'h44, 32'h1, 32'h2, 1'b0, 1'b0);
        tick(); model_count(1'b1);
        n_vec++; if (res_taken !== 1'b1) begin n_err++; $error("FAIL t4_bne_taken observed=%0h", res_taken); end
        n_vec++; if (lk_taken !== 1'b1) begin n_err++; $error("FAIL t4_bne_lk observed=%0h", lk_taken); end
        check_stats("t4b");

        lk_pc = 32'h80;
        for (int k = 0; k < 4; k++) begin
            drive(((k % 2) == 0) ? 3'd7 : 3'd0, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0);
            tick();
            n_vec++;
            if (res_taken !== ((k % 2) == 0)) begin
                n_err++;
                $error("FAIL t5_taken k=%0d observed=%0h", k, res_taken);
            end
            n_vec++;
            if (res_mispred !== ((k % 2) == 0)) begin
                n_err++;
                $error("FAIL t5_mispred k=%0d observed=%0h", k, res_mispred);
            end
        end
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL t5_lk_01 observed=%0h", lk_taken); end
        drive(3'd3, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); model_count(1'b1);
        n_vec++; if (lk_taken !== 1'b1) begin n_err++; $error("FAIL t5_lk_10 observed=%0h", lk_taken); end
        check_stats("t5");

        drive(3'd6, 32'h80, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); m_br = 4'h0; m_mp = 4'h0;
        reset = 1'b0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $error("FAIL rst_valid observed=%0h", res_valid); end
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $error("FAIL rst_taken observed=%0h", res_taken); end
        n_vec++; if (lk_taken !== 1'b0) begin n_err++; $error("FAIL rst_lk80 observed=%0h", lk_taken); end
        check_stats("rst");

        for (int k = 0; k < 20; k++) begin
            drive(3'd6, 32'h10, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
            tick(); model_count(1'b1);
        end
        n_vec++; if (stat_branches !== (STATS ? 4'hF : 4'h0)) begin n_err++; $error("FAIL t6_sat_br observed=%0h", stat_branches); end
        n_vec++; if (stat_mispred !== (STATS ? 4'hF : 4'h0)) begin n_err++; $error("FAIL t6_sat_mp observed=%0h", stat_mispred); end
        check_stats("t6");
        reset = 1'b1;
        tick(); m_br = 4'h0; m_mp = 4'h0;
        reset = 1'b0;
        req_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $error("FAIL t6_rst_valid observed=%0h", res_valid); end
        n_vec++; if (res_mispred !== 1'b0) begin n_err++; $error("FAIL t6_rst_mispred observed=%0h", res_mispred); end
        check_stats("t6_rst");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
